// File: rtl/ram_bist_ctrl.sv
// BIST engine for an active-low single-port SRAM: write sweep, idle gap, read sweep with compare.
// Defining RAM_BIST_INVERT_PASS_EN adds a second sweep that uses the bitwise-inverted pattern.
module ram_bist_ctrl #(
   parameter int          AW      = 16,
   parameter int          DW      = 8,
   parameter int          RD_LAT  = 1,
   parameter int          GAP_CYC = 10,
   parameter logic [31:0] SEED    = 32'h1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          start,
   input  logic [1:0]    mode,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [15:0]   err_cnt,
   output logic [AW-1:0] fail_adr,
   output logic [AW-1:0] adr,
   output logic [DW-1:0] d,
   output logic          enb,
   output logic          web,
   output logic          oeb,
   input  logic [DW-1:0] q,
   output logic [2:0]    dbg_state
);
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_GAP, S_READ, S_FLUSH, S_FIN} state_t;

   localparam logic [31:0]   POLY     = 32'h8020_0003;
   localparam logic [31:0]   SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam logic [AW-1:0] ADR_MAX  = {AW{1'b1}};
   localparam logic [AW-1:0] ADR_ONE  = AW'(1);

   function automatic logic [DW-1:0] cb_even();
      logic [DW-1:0] v;
      for (int i = 0; i < DW; i++) v[i] = (i % 2 == 0);
      return v;
   endfunction

   localparam logic [DW-1:0] CB_EVEN = cb_even();

   // Galois form, shifting right; taps x^32+x^22+x^2+x+1 map to mask bits 31,21,1,0.
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
   endfunction

   function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [DW-1:0] l,
                                         input logic [1:0] m, input logic iv);
      logic [DW-1:0] v;
      case (m)
         2'd0:    v = l;
         2'd1:    v = a[0] ? ~CB_EVEN : CB_EVEN;
         2'd2:    v = DW'(a);
         default: v = {DW{1'b1}};
      endcase
      return iv ? ~v : v;
   endfunction

   state_t          state;
   logic [1:0]      mode_q;
   logic [31:0]     lfsr;
   logic [15:0]     gap_cnt;
   logic [1:0]      fl_cnt;
   logic [AW-1:0]   adr_nx;
   logic            mism;
   logic [15:0]     err_nx;

`ifdef RAM_BIST_INVERT_PASS_EN
   logic            inv;
`else
   localparam logic inv = 1'b0;
`endif

   // Stage 0 is loaded together with the read command; stage RD_LAT lines up with Q.
   logic            pv [0:RD_LAT];
   logic [DW-1:0]   pe [0:RD_LAT];
   logic [AW-1:0]   pa [0:RD_LAT];

   assign dbg_state = state;
   assign adr_nx    = adr + ADR_ONE;

   always_comb begin
      mism   = pv[RD_LAT] && (q != pe[RD_LAT]);
      err_nx = err_cnt;
      if (mism && (err_cnt != 16'hFFFF)) err_nx = err_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= 16'h0;
         fail_adr <= '0;
         adr      <= '0;
         d        <= '0;
         enb      <= 1'b1;
         web      <= 1'b1;
         oeb      <= 1'b1;
         mode_q   <= 2'd0;
         lfsr     <= SEED_EFF;
         gap_cnt  <= 16'h0;
         fl_cnt   <= 2'd0;
`ifdef RAM_BIST_INVERT_PASS_EN
         inv      <= 1'b0;
`endif
         for (int i = 0; i <= RD_LAT; i++) begin
            pv[i] <= 1'b0;
            pe[i] <= '0;
            pa[i] <= '0;
         end
      end else begin
         err_cnt <= err_nx;
         if (mism && (err_cnt == 16'h0)) fail_adr <= pa[RD_LAT];
         for (int i = 1; i <= RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pe[i] <= pe[i-1];
            pa[i] <= pa[i-1];
         end
         pv[0] <= 1'b0;

         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  state    <= S_WRITE;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  err_cnt  <= 16'h0;
                  fail_adr <= '0;
                  mode_q   <= mode;
                  enb      <= 1'b0;
                  web      <= 1'b0;
                  oeb      <= 1'b1;
                  adr      <= '0;
                  d        <= pat({AW{1'b0}}, SEED_EFF[DW-1:0], mode, 1'b0);
                  lfsr     <= lfsr_step(SEED_EFF);
`ifdef RAM_BIST_INVERT_PASS_EN
                  inv      <= 1'b0;
`endif
               end
            end

            S_WRITE: begin
               if (adr == ADR_MAX) begin
                  state   <= S_GAP;
                  enb     <= 1'b1;
                  web     <= 1'b1;
                  adr     <= '0;
                  d       <= '0;
                  gap_cnt <= 16'(GAP_CYC - 1);
                  lfsr    <= SEED_EFF;
               end else begin
                  adr  <= adr_nx;
                  d    <= pat(adr_nx, lfsr[DW-1:0], mode_q, inv);
                  lfsr <= lfsr_step(lfsr);
               end
            end

            S_GAP: begin
               if (gap_cnt != 16'h0) begin
                  gap_cnt <= gap_cnt - 16'h1;
               end else begin
                  state <= S_READ;
                  enb   <= 1'b0;
                  oeb   <= 1'b0;
                  adr   <= '0;
                  pv[0] <= 1'b1;
                  pe[0] <= pat({AW{1'b0}}, lfsr[DW-1:0], mode_q, inv);
                  pa[0] <= '0;
                  lfsr  <= lfsr_step(lfsr);
               end
            end

            S_READ: begin
               if (adr == ADR_MAX) begin
                  state  <= S_FLUSH;
                  enb    <= 1'b1;
                  oeb    <= 1'b1;
                  adr    <= '0;
                  fl_cnt <= 2'(RD_LAT - 1);
               end else begin
                  adr   <= adr_nx;
                  pv[0] <= 1'b1;
                  pe[0] <= pat(adr_nx, lfsr[DW-1:0], mode_q, inv);
                  pa[0] <= adr_nx;
                  lfsr  <= lfsr_step(lfsr);
               end
            end

            S_FLUSH: begin
               if (fl_cnt != 2'd0) begin
                  fl_cnt <= fl_cnt - 2'd1;
               end
`ifdef RAM_BIST_INVERT_PASS_EN
               else if (!inv) begin
                  state <= S_WRITE;
                  inv   <= 1'b1;
                  enb   <= 1'b0;
                  web   <= 1'b0;
                  adr   <= '0;
                  d     <= pat({AW{1'b0}}, SEED_EFF[DW-1:0], mode_q, 1'b1);
                  lfsr  <= lfsr_step(SEED_EFF);
               end
`endif
               else begin
                  // The last read compares on this same edge, so PASS must see err_nx.
                  state <= S_FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nx == 16'h0);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: SRAM model with stuck-at faults, sweep-level reference trace and result model.
module tb_ram_bist_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RD_LAT = 1;
  localparam int GAP_CYC = 2;
  localparam int NW = 16;
  localparam int EW = 18;
  localparam logic [31:0] POLY = 32'h8020_0003;
`ifdef RAM_BIST_INVERT_PASS_EN
  localparam int PASSES = 2;
  localparam int BUSY_LIT = 70;
`else
  localparam int PASSES = 1;
  localparam int BUSY_LIT = 35;
`endif

  logic clk, rstn, start;
  logic [1:0] mode;
  logic busy, done, pass, enb, web, oeb;
  logic [15:0] err_cnt;
  logic [AW-1:0] fail_adr, adr;
  logic [DW-1:0] d, q;
  logic [2:0] dbg_state;

  logic [DW-1:0] mem [NW];
  logic [DW-1:0] s0 [NW];
  logic [DW-1:0] s1 [NW];
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .GAP_CYC(GAP_CYC), .SEED(32'h1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_adr(fail_adr),
    .adr(adr), .d(d), .enb(enb), .web(web), .oeb(oeb), .q(q), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model, one-cycle read latency, stuck-at faults applied on read
  always @(posedge clk) begin
    if (!enb && !web) mem[adr] <= d;
    if (!enb && !oeb && web) q <= (mem[adr] & ~s0[adr]) | s1[adr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Pattern word i of a sweep, derived directly from the pattern rules.
  function automatic logic [DW-1:0] pat(input int i, input logic [1:0] m, input bit iv);
    logic [31:0] s;
    logic [DW-1:0] v;
    case (m)
      2'd0: begin
        s = 32'h1;
        for (int k = 0; k < i; k++) s = s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
        v = s[DW-1:0];
      end
      2'd1: v = (i % 2 == 0) ? 8'h55 : 8'hAA;
      2'd2: v = 8'(i);
      default: v = 8'hFF;
    endcase
    return iv ? ~v : v;
  endfunction

  task automatic clear_faults();
    for (int i = 0; i < NW; i++) begin
      s0[i] = '0;
      s1[i] = '0;
    end
  endtask

  // driver + per-cycle compare against the reference trace
  task automatic run_test(input logic [1:0] m, input int poke_at, input string name);
    logic [EW-1:0] e;
    logic [16:0] act, mask;
    logic [DW-1:0] w, r;
    int exp_err, exp_fail, cyc, blen, extra;
    exp_q.delete();
    exp_err = 0;
    exp_fail = 0;
    for (int p = 0; p < PASSES; p++) begin
      for (int i = 0; i < NW; i++)
        exp_q.push_back({1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'(i), pat(i, m, p != 0), 1'b0});
      for (int g = 0; g < GAP_CYC; g++)
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0});
      for (int i = 0; i < NW; i++) begin
        exp_q.push_back({1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'(i), 8'h00, 1'b0});
        w = pat(i, m, p != 0);
        r = (w & ~s0[i]) | s1[i];
        if (r != w) begin
          if (exp_err == 0) exp_fail = i;
          exp_err++;
        end
      end
      for (int f = 0; f < RD_LAT; f++)
        exp_q.push_back({1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b0});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1});

    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom_range(0, 3));
    cyc = 0;
    blen = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = {busy, enb, web, oeb, adr, d, done};
      mask = {4'hF, 4'hF, e[17] ? 8'hFF : 8'h00, 1'b1};
      check($sformatf("%s_m%0d_cyc%0d", name, m, cyc), act & mask, e[16:0] & mask);
      if (busy) blen++;
      start = (cyc == poke_at);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    extra = 0;
    while (busy && extra < 300) begin
      blen++;
      extra++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, blen, BUSY_LIT);
    check({name, "_err_cnt"}, err_cnt, exp_err);
    check({name, "_fail_adr"}, fail_adr, exp_fail);
    check({name, "_pass"}, {done, pass}, {1'b1, exp_err == 0});
  endtask

  initial begin : main
    int cyc, nf, fa, fb;
    rstn = 1'b0;
    start = 1'b0;
    mode = 2'd0;
    q = '0;
    clear_faults();
    #12;
    check("reset_outputs", {busy, done, pass, err_cnt, fail_adr, adr, d, enb, web, oeb},
          {1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    rstn = 1'b1;

    // pin the reference model with hand-computed values
    check("model_lfsr_w0", pat(0, 2'd0, 0), 8'h01);
    check("model_lfsr_w1", pat(1, 2'd0, 0), 8'h03);
    check("model_lfsr_w2", pat(2, 2'd0, 0), 8'h02);
    check("model_cb_w0", pat(0, 2'd1, 0), 8'h55);
    check("model_cb_w1", pat(1, 2'd1, 0), 8'hAA);
    check("model_adr_w13", pat(13, 2'd2, 0), 8'h0D);
    check("model_solid_inv", pat(5, 2'd3, 1), 8'h00);

    for (int m = 0; m < 4; m++) begin
      run_test(2'(m), -1, "clean");
      check($sformatf("clean_m%0d_lit", m), {pass, err_cnt}, {1'b1, 16'h0});
    end

    clear_faults();
    s0[6] = 8'h08;
    run_test(2'd3, -1, "flt6");
    check("flt6_lit", {pass, err_cnt, fail_adr}, {1'b0, 16'd1, 4'd6});

    clear_faults();
    s0[2] = 8'h01;
    s0[9] = 8'h10;
    run_test(2'd3, 7, "flt2_9");
    check("flt2_9_lit", {pass, err_cnt, fail_adr}, {1'b0, 16'd2, 4'd2});

    // asynchronous reset in the middle of the write sweep
    clear_faults();
    exp_q.delete();
    @(negedge clk);
    mode = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(adr == 4'd5 && !web) && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_write_adr5", {adr, web, busy}, {4'd5, 1'b0, 1'b1});
    #2 rstn = 1'b0;
    #1 check("async_rst", {busy, done, pass, err_cnt, adr, enb, web, oeb},
             {1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b1});
    @(negedge clk);
    check("rst_held", {busy, done, enb, web, oeb}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    rstn = 1'b1;
    run_test(2'd2, -1, "after_rst");

    // randomized faults, modes and start pokes while busy
    repeat (8) begin
      clear_faults();
      nf = $urandom_range(0, 3);
      for (int k = 0; k < nf; k++) begin
        fa = $urandom_range(0, NW - 1);
        fb = $urandom_range(0, DW - 1);
        if ($urandom_range(0, 1) == 1) s1[fa][fb] = 1'b1;
        else s0[fa][fb] = 1'b1;
      end
      run_test(2'($urandom_range(0, 3)), $urandom_range(0, 30), "rand");
    end

    repeat ($urandom_range(2, 6)) @(negedge clk);
    check("done_held", {done, busy}, {1'b1, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
